button_conditioner: RTL and testbench

Upstream input stage between the raw board pushbuttons (Up/Down/Left/Right/Shoot) and the drawing/game-logic stage. It runs in the 25 MHz pixel clock domain, where it:
- synchronises each raw button,
- debounces it,
- produces a clean level, a one-cycle press pulse, a one-cycle release pulse, and an optional auto-repeat press pulse while the button is held.

The drawing stage consumes the clean levels or pulses in place of raw button pins.

---
 rtl/button_conditioner.sv | 167 ++++++++++++++++
 tb/tb_button_conditioner.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Pushbutton input stage: per-channel two-flop synchroniser, debouncer and
// press/release/auto-repeat pulse generator, all outputs registered.
module button_conditioner #(
    parameter int                  NUM_BTNS        = 5,
    parameter int                  DEBOUNCE_CYCLES = 250000,
    parameter int                  REPEAT_DELAY    = 10000000,
    parameter int                  REPEAT_PERIOD   = 2500000,
    parameter logic [NUM_BTNS-1:0] REPEAT_MASK     = 5'b01111
) (
    input  logic                Master_Clock_In,
    input  logic                Reset_N_In,
    input  logic [NUM_BTNS-1:0] Btn_Raw_In,
    output logic [NUM_BTNS-1:0] Btn_Level_Out,
    output logic [NUM_BTNS-1:0] Btn_Press_Out,
    output logic [NUM_BTNS-1:0] Btn_Release_Out,
    output logic                Any_Press_Out
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX);

    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]  DB_ONE      = DB_W'(1);
    localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);
    localparam logic [REP_W-1:0] REP_ONE     = REP_W'(1);

    typedef enum logic [1:0] {
        RELEASED,
        HELD,
        REPEATING
    } state_t;

    logic [NUM_BTNS-1:0] sync_q1;
    logic [NUM_BTNS-1:0] sync_q2;
    logic [NUM_BTNS-1:0] level;
    logic [NUM_BTNS-1:0] press;
    logic [NUM_BTNS-1:0] rel;
    logic [NUM_BTNS-1:0] press_next;
    logic                any_press;

    always_ff @(posedge Master_Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= Btn_Raw_In;
            sync_q2 <= sync_q1;
        end
    end

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_chan
        logic [DB_W-1:0]  db_cnt;
        logic             level_q;
        logic [REP_W-1:0] rep_cnt;
        logic [REP_W-1:0] rep_cnt_next;
        state_t           state;
        state_t           state_next;
        logic             press_q;
        logic             press_c;
        logic             rel_q;
        logic             rel_c;
        logic             accept;
        logic             rise;
        logic             fall;

        // Accept fires on the edge where the new level is committed, so the
        // FSM pulses land in the same cycle as the level change.
        assign accept = (sync_q2[i] != level_q) && (db_cnt == DB_LAST);
        assign rise   = accept & sync_q2[i];
        assign fall   = accept & ~sync_q2[i];

        always_ff @(posedge Master_Clock_In or negedge Reset_N_In) begin
            if (!Reset_N_In) begin
                db_cnt  <= '0;
                level_q <= 1'b0;
            end else if (sync_q2[i] == level_q) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                level_q <= sync_q2[i];
                db_cnt  <= '0;
            end else begin
                db_cnt <= db_cnt + DB_ONE;
            end
        end

        // A release always takes priority over a coincident repeat tick.
        always_comb begin
            state_next   = state;
            rep_cnt_next = rep_cnt;
            press_c      = 1'b0;
            rel_c        = 1'b0;
            case (state)
                RELEASED: begin
                    if (rise) begin
                        press_c      = 1'b1;
                        rep_cnt_next = '0;
                        state_next   = HELD;
                    end
                end
                HELD: begin
                    if (fall) begin
                        rel_c      = 1'b1;
                        state_next = RELEASED;
                    end else if (REPEAT_MASK[i]) begin
                        if (rep_cnt == DELAY_LAST) begin
                            press_c      = 1'b1;
                            rep_cnt_next = '0;
                            state_next   = REPEATING;
                        end else begin
                            rep_cnt_next = rep_cnt + REP_ONE;
                        end
                    end
                end
                REPEATING: begin
                    if (fall) begin
                        rel_c      = 1'b1;
                        state_next = RELEASED;
                    end else if (rep_cnt == PERIOD_LAST) begin
                        press_c      = 1'b1;
                        rep_cnt_next = '0;
                    end else begin
                        rep_cnt_next = rep_cnt + REP_ONE;
                    end
                end
                default: begin
                    state_next = RELEASED;
                end
            endcase
        end

        always_ff @(posedge Master_Clock_In or negedge Reset_N_In) begin
            if (!Reset_N_In) begin
                state   <= RELEASED;
                rep_cnt <= '0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                state   <= state_next;
                rep_cnt <= rep_cnt_next;
                press_q <= press_c;
                rel_q   <= rel_c;
            end
        end

        assign level[i]      = level_q;
        assign press[i]      = press_q;
        assign rel[i]        = rel_q;
        assign press_next[i] = press_c;
    end

    // Registered from the per-channel next-press terms so it lines up with Press.
    always_ff @(posedge Master_Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            any_press <= 1'b0;
        end else begin
            any_press <= |press_next;
        end
    end

    assign Btn_Level_Out   = level;
    assign Btn_Press_Out   = press;
    assign Btn_Release_Out = rel;
    assign Any_Press_Out   = any_press;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with small debounce/repeat constants;
// expected pulses are derived from edge numbers counted after reset release.
module tb_button_conditioner;

    localparam int NUM_BTNS = 5;
    localparam int DB       = 4;
    localparam int DELAY    = 10;
    localparam int PERIOD   = 3;

    logic                clk;
    logic                rst_n;
    logic [NUM_BTNS-1:0] raw;
    logic [NUM_BTNS-1:0] level;
    logic [NUM_BTNS-1:0] press;
    logic [NUM_BTNS-1:0] rel;
    logic                any_press;

    int total;
    int bad;

    button_conditioner #(
        .NUM_BTNS        (NUM_BTNS),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (DELAY),
        .REPEAT_PERIOD   (PERIOD),
        .REPEAT_MASK     (5'b01111)
    ) dut (
        .Master_Clock_In (clk),
        .Reset_N_In      (rst_n),
        .Btn_Raw_In      (raw),
        .Btn_Level_Out   (level),
        .Btn_Press_Out   (press),
        .Btn_Release_Out (rel),
        .Any_Press_Out   (any_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // After return, the next rising edge is edge 1 and raw already holds raw_init.
    task automatic applyReset(input logic [NUM_BTNS-1:0] raw_init);
        raw   = raw_init;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    // Channel ch held from edge 1; raw drops so that edge drop_edge samples 0.
    task automatic applyStimulus(input int ch, input int drop_edge, input int last_edge, input bit rep);
        int first;
        int first_rep;
        int rel_edge;
        logic [NUM_BTNS-1:0] exp_press;
        logic [NUM_BTNS-1:0] exp_rel;
        logic [NUM_BTNS-1:0] exp_level;
        first     = DB + 2;
        first_rep = first + DELAY;
        rel_edge  = drop_edge + DB + 1;
        for (int e = 1; e <= last_edge; e++) begin
            if (e == drop_edge) raw[ch] = 1'b0;
            tick();
            exp_press = '0;
            exp_rel   = '0;
            exp_level = '0;
            if (e == first || (rep && e >= first_rep && (e - first_rep) % PERIOD == 0 && e < rel_edge))
                exp_press[ch] = 1'b1;
            if (e == rel_edge) exp_rel[ch] = 1'b1;
            if (e >= first && e < rel_edge) exp_level[ch] = 1'b1;
            checkOutput($sformatf("ch%0d_e%0d_press", ch, e), 32'(press), 32'(exp_press));
            checkOutput($sformatf("ch%0d_e%0d_release", ch, e), 32'(rel), 32'(exp_rel));
            checkOutput($sformatf("ch%0d_e%0d_level", ch, e), 32'(level), 32'(exp_level));
            checkOutput($sformatf("ch%0d_e%0d_any", ch, e), 32'(any_press), 32'(exp_press != '0));
        end
    endtask

    initial begin
        logic [0:8] bounce;
        total = 0;
        bad   = 0;

        // Raw activity during reset must not reach the outputs.
        raw   = '1;
        rst_n = 1'b0;
        repeat (3) tick();
        checkOutput("rst_level", 32'(level), 32'h0);
        checkOutput("rst_press", 32'(press), 32'h0);
        checkOutput("rst_release", 32'(rel), 32'h0);
        checkOutput("rst_any", 32'(any_press), 32'h0);

        applyReset(5'b00001);
        applyStimulus(0, 1000, 12, 1'b1);

        applyReset(5'b00000);
        bounce = 9'b101101111;
        for (int e = 1; e <= 16; e++) begin
            raw[1] = (e <= 9) ? bounce[e-1] : 1'b1;
            tick();
            checkOutput($sformatf("bounce_e%0d_press", e), 32'(press), (e == 11) ? 32'h2 : 32'h0);
            checkOutput($sformatf("bounce_e%0d_level", e), 32'(level), (e >= 11) ? 32'h2 : 32'h0);
            checkOutput($sformatf("bounce_e%0d_release", e), 32'(rel), 32'h0);
        end

        applyReset(5'b00100);
        applyStimulus(2, 37, 45, 1'b1);

        applyReset(5'b10000);
        applyStimulus(4, 37, 45, 1'b0);

        // Release lands exactly on a repeat terminal count (edge 25).
        applyReset(5'b00010);
        applyStimulus(1, 20, 28, 1'b1);

        applyReset(5'b01001);
        repeat (5) tick();
        checkOutput("dual_pre_press", 32'(press), 32'h0);
        tick();
        checkOutput("dual_press", 32'(press), 32'h9);
        checkOutput("dual_any", 32'(any_press), 32'h1);
        tick();
        checkOutput("dual_post_press", 32'(press), 32'h0);
        checkOutput("dual_post_any", 32'(any_press), 32'h0);

        // Async reset while channel 3 is repeating, with raw still held.
        applyReset(5'b01000);
        applyStimulus(3, 1000, 19, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_press", 32'(press), 32'h0);
        checkOutput("async_rst_level", 32'(level), 32'h0);
        checkOutput("async_rst_any", 32'(any_press), 32'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        applyStimulus(3, 1000, 20, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
